// File: rtl/inc_seq.sv
// -----------------------------------------------------------------------------
// inc_seq -- multi-cycle incrementer
//
// Computes OUT = A + 1 (mod 2^WIDTH) by rippling a carry through the operand
// CHUNK bits at a time, one chunk per clock. The latency is always
// N = WIDTH/CHUNK RUN cycles, even when the carry dies out early.
//
// Parameters
//   WIDTH  operand/result width in bits (must be a multiple of CHUNK)
//   CHUNK  bits added per RUN cycle
//
// Ports
//   clk    single clock, rising-edge active
//   rst    synchronous active-high reset, takes priority over start
//   start  request to increment A; accepted in IDLE or DONE, ignored in RUN
//   A      operand, sampled only on the edge that accepts start
//   OUT    registered result, updated only on the edge entering DONE
//   Cout   registered carry out (set only when A was all ones)
//   busy   high while the FSM is in RUN
//   done   one-cycle pulse while the FSM is in DONE (OUT/Cout newly valid)
// -----------------------------------------------------------------------------
module inc_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] OUT,
    output logic             Cout,
    output logic             busy,
    output logic             done
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_params
            $error("inc_seq: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic [WIDTH-1:0]  work;      // operand being incremented in place
    logic              carry;     // carry into the chunk at idx
    logic [IDXW-1:0]   idx;       // chunk currently being processed

    logic [CHUNK-1:0]  cur_chunk;
    logic [CHUNK:0]    chunk_sum;
    logic [WIDTH-1:0]  work_nx;
    logic              last_chunk;
    logic              accept;

    // -------------------------------------------------------------------------
    // Chunk datapath: select chunk[idx], add the carry, and splice the sum
    // back into a copy of the work register.
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the loop, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        cur_chunk = '0;
        work_nx   = work;
        for (int i = 0; i < N; i++) begin
            if (idx == i[IDXW-1:0]) begin
                cur_chunk = work[i*CHUNK +: CHUNK];
            end
        end
        chunk_sum = {1'b0, cur_chunk} + {{CHUNK{1'b0}}, carry};
        for (int i = 0; i < N; i++) begin
            if (idx == i[IDXW-1:0]) begin
                work_nx[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
            end
        end
    end

    assign last_chunk = (idx == IDXW'(N - 1));

    // A new operation can only be accepted outside RUN; start in RUN is a
    // don't-care and must not disturb the operation in flight.
    assign accept = start && (state != RUN);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                // Fixed latency: leave RUN only after the top chunk, even if
                // the carry has already gone to zero.
                if (last_chunk) state_nx = DONE;
            end
            DONE: begin
                state_nx = start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the work register is a plain vector, not a memory array, so
            // clearing it on reset is cheap and keeps an aborted operand from
            // lingering in the datapath.
            state <= IDLE;
            work  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            OUT   <= '0;
            Cout  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                work  <= A;
                carry <= 1'b1;
                idx   <= '0;
            end else if (state == RUN) begin
                work  <= work_nx;
                carry <= chunk_sum[CHUNK];
                idx   <= last_chunk ? '0 : idx + 1'b1;
                // OUT/Cout are published only on the final chunk, so a reset
                // mid-RUN can never expose a partial result.
                if (last_chunk) begin
                    OUT  <= work_nx;
                    Cout <= chunk_sum[CHUNK];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Status decodes of the registered state
    // -------------------------------------------------------------------------
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_inc_seq.sv
// -----------------------------------------------------------------------------
// tb_inc_seq -- self-checking bench for inc_seq (WIDTH=32, CHUNK=8)
//
// Inputs are driven and outputs sampled on the falling edge. Expected results
// come from plain 33-bit arithmetic on the operand; expected timing comes
// from the fixed latency of N RUN cycles followed by one DONE cycle.
// -----------------------------------------------------------------------------
module tb_inc_seq;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int N     = WIDTH / CHUNK;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] OUT;
    logic             Cout;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    // Model of the architecturally visible result registers.
    logic [WIDTH-1:0] last_out  = '0;
    logic             last_cout = 1'b0;
    int               done_cyc  = 0;

    inc_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .OUT   (OUT),
        .Cout  (Cout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Runs one operation. Call at a falling edge; returns at the falling edge
    // of the DONE cycle with start already dropped, so the caller may either
    // chain another op (start accepted in DONE) or idle.
    // noise: 0 = quiet inputs during RUN, 1 = random start/A, 2 = start=1, A=0
    task automatic op(input logic [WIDTH-1:0] a, input int noise);
        logic [WIDTH-1:0] exp_out;
        logic             exp_cout;
        logic [WIDTH:0]   wide;
        wide     = {1'b0, a} + 33'd1;
        exp_out  = wide[WIDTH-1:0];
        exp_cout = wide[WIDTH];
        start = 1'b1;
        A     = a;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check("busy_in_run", busy, 1);
            check("done_in_run", done, 0);
            check("out_hold",    OUT,  last_out);
            check("cout_hold",   Cout, last_cout);
            case (noise)
                1:       begin start = 1'($urandom); A = $urandom; end
                2:       begin start = 1'b1;         A = '0;       end
                default: begin start = 1'b0;                       end
            endcase
            @(negedge clk);
        end
        start = 1'b0;
        A     = $urandom;
        check("done_pulse", done, 1);
        check("busy_done",  busy, 0);
        check("out",        OUT,  exp_out);
        check("cout",       Cout, exp_cout);
        last_out  = exp_out;
        last_cout = exp_cout;
        done_cyc  = cyc;
    endtask

    task automatic idle(input int cycles);
        start = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("idle_done", done, 0);
            check("idle_busy", busy, 0);
            check("idle_out",  OUT,  last_out);
        end
    endtask

    initial begin
        int first_done;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        repeat (2) @(negedge clk);
        check("rst_out",  OUT,  0);
        check("rst_cout", Cout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // Reset wins over a simultaneous start.
        start = 1'b1;
        A     = 32'h0000_0123;
        @(negedge clk);
        check("rst_prio_busy", busy, 0);
        check("rst_prio_done", done, 0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

        // Directed values, including chunk-boundary carries and overflow.
        op(32'h0000_0000, 0); idle(1);
        op(32'hFFFF_FFFF, 0); idle(1);
        op(32'h0000_00FF, 0); idle(1);
        op(32'h7FFF_FFFF, 0); idle(1);

        // A changed and start pulsed during RUN: single result, no extra op.
        op(32'h1234_5678, 2);
        idle(N + 2);

        // Reset at the second RUN edge aborts with no result published.
        start = 1'b1;
        A     = 32'h0000_FFFF;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy_pre", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_out",  OUT,  0);
        check("abort_cout", Cout, 0);
        last_out  = '0;
        last_cout = 1'b0;
        idle(N + 2);

        // Back-to-back: second start accepted during DONE.
        op(32'h0000_0005, 0);
        first_done = done_cyc;
        op(32'h0000_0009, 0);
        check("b2b_spacing", 64'(done_cyc - first_done), 64'(N + 1));
        idle(1);

        // Randomized operands with random chaining and RUN-time noise.
        for (int t = 0; t < 40; t++) begin
            logic [WIDTH-1:0] a;
            case ($urandom_range(0, 5))
                0:       a = 32'hFFFF_FFFF;
                1:       a = {$urandom_range(0, 255) << 24} | 32'h00FF_FFFF;
                default: a = $urandom;
            endcase
            op(a, int'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/inc_seq.md
INC_SEQ -- requirements
Module: inc_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 The module SHALL have parameter CHUNK, default 8, the bits processed per RUN cycle; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit, a request to increment A, sampled on the rising edge.
REQ-006 The module SHALL have port A, input, WIDTH bits, the operand, sampled only on the edge that accepts start.
REQ-007 The module SHALL have port OUT, output, WIDTH bits, the registered result A+1 mod 2^WIDTH.
REQ-008 The module SHALL have port Cout, output, 1 bit, the registered carry out (overflow indicator).
REQ-009 The module SHALL have port busy, output, 1 bit, high while in RUN.
REQ-010 The module SHALL have port done, output, 1 bit, a one-cycle pulse when OUT/Cout are newly valid.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN, DONE; N = WIDTH/CHUNK (4 at default).
REQ-012 In IDLE or DONE, with start=1 at an edge, the block SHALL latch A into an internal work register, set the internal carry to 1, set the chunk index to 0 and enter RUN.
REQ-013 In IDLE with start=0, the block SHALL remain in IDLE; in DONE with start=0, it SHALL go to IDLE at the next edge.
REQ-014 Each RUN edge SHALL add the internal carry to work chunk[index] (CHUNK bits), write the sum back and set the carry to that chunk's carry out, then advance the index.
REQ-015 The edge that processes chunk N-1 SHALL load OUT from the final work register, load Cout from the final carry, and enter DONE.
REQ-016 Latency SHALL be fixed: start accepted at edge 0; done=1 for exactly the cycle after edge N; no early termination when the carry becomes 0.
REQ-017 busy SHALL equal (state==RUN) and done SHALL equal (state==DONE), both registered-state decodes.
REQ-018 start SHALL be ignored while in RUN, and A changes during RUN SHALL NOT affect the result.
REQ-019 OUT and Cout SHALL hold their previous values throughout RUN and SHALL change only on the edge entering DONE or on reset.
REQ-020 Back-to-back operation SHALL be supported: start=1 during DONE SHALL be accepted, giving a new done pulse N+1 edges later.
REQ-021 Cout SHALL be 1 only when A equals all ones, in which case OUT SHALL be 0.

Reset
REQ-022 When rst=1 at an edge, the block SHALL set state to IDLE, OUT to 0, Cout to 0, busy to 0, done to 0, and the work register, carry and index to 0.
REQ-023 rst SHALL take priority over start at the same edge.
REQ-024 rst asserted mid-RUN SHALL abort the operation with no done pulse, and the aborted result SHALL never appear on OUT.

Verification
REQ-025 The bench SHALL check: A=0x00000000 with start for 1 cycle -> busy for 4 cycles, then done for 1 cycle with OUT=0x00000001, Cout=0.
REQ-026 The bench SHALL check: A=0xFFFFFFFF -> OUT=0x00000000, Cout=1 at done.
REQ-027 The bench SHALL check the chunk-boundary carry cases: A=0x000000FF -> OUT=0x00000100; A=0x7FFFFFFF -> OUT=0x80000000, Cout=0.
REQ-028 The bench SHALL check: start with A=0x12345678, then A changed to 0 and start pulsed during RUN -> single done with OUT=0x12345679, and no extra operation started.
REQ-029 The bench SHALL check: start with A=0x0000FFFF, rst at the second RUN edge -> no done, OUT=0 and Cout=0, busy=0 next cycle.
REQ-030 The bench SHALL check: A=0x00000005 accepted, then start with A=0x00000009 held during DONE -> done pulses 5 edges apart with OUT=0x00000006, then 0x0000000A.
